// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer. Every add, subtract and negate
// runs through one shared 32-bit ripple-carry adder, one operation per cycle.
module muldiv_seq #(
  parameter int unsigned XLEN         = 32,
  parameter bit          FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [2:0] {
    IDLE, NEG_A, NEG_B, CALC, FIX_LO, FIX_HI, DONE
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_a, r_b, r_hi, r_lo, r_result;
  logic [4:0]      r_cnt, w_cnt_inc;
  logic            r_sa, r_sb, r_dz, r_c, r_busy, r_done;
  logic [XLEN-1:0] w_add_a, w_add_b, w_sum, w_rs;
  logic            w_add_cin, w_cout;
  logic            w_is_div, w_is_rem, w_sgn_a, w_sgn_b, w_sa, w_sb;
  logic            w_dz, w_ovf, w_np, w_nq, w_qbit;

  assign w_is_div = r_op[2];
  assign w_is_rem = r_op[2] & r_op[1];
  assign w_sgn_a  = (r_op == 3'd1) || (r_op == 3'd2) || (r_op == 3'd4) || (r_op == 3'd6);
  assign w_sgn_b  = (r_op == 3'd1) || (r_op == 3'd4) || (r_op == 3'd6);
  assign w_sa     = w_sgn_a & r_a[XLEN-1];
  assign w_sb     = w_sgn_b & r_b[XLEN-1];
  assign w_dz     = w_is_div & (r_b == '0);
  assign w_ovf    = w_is_div & ~r_op[0] & (r_a == MIN_NEG) & (r_b == '1);
  assign w_np     = r_sa ^ r_sb;
  assign w_nq     = w_np & ~r_dz;
  assign w_rs     = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
  // The shifted remainder is 33 bits wide; its dropped MSB forces a subtract.
  assign w_qbit   = w_cout | r_hi[XLEN-1];

  always_comb begin
    logic c;
    c = w_add_cin;
    w_sum = '0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      w_sum[i] = w_add_a[i] ^ w_add_b[i] ^ c;
      c = (w_add_a[i] & w_add_b[i]) | (c & (w_add_a[i] ^ w_add_b[i]));
    end
    w_cout = c;
  end

  always_comb begin
    logic c;
    c = 1'b1;
    w_cnt_inc = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      w_cnt_inc[i] = r_cnt[i] ^ c;
      c = c & r_cnt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_add_a     = '0;
    w_add_b     = '0;
    w_add_cin   = 1'b0;
    case (r_state)
      IDLE: if (start) w_state_nxt = NEG_A;
      NEG_A: begin
        w_add_a     = w_sa ? ~r_a : r_a;
        w_add_cin   = w_sa;
        w_state_nxt = (FAST_SPECIAL && (w_dz || w_ovf)) ? DONE : NEG_B;
      end
      NEG_B: begin
        w_add_a     = w_sb ? ~r_b : r_b;
        w_add_cin   = w_sb;
        w_state_nxt = CALC;
      end
      CALC: begin
        if (w_is_div) begin
          w_add_a   = w_rs;
          w_add_b   = ~r_b;
          w_add_cin = 1'b1;
        end else begin
          w_add_a = r_hi;
          w_add_b = r_lo[0] ? r_a : '0;
        end
        if (r_cnt == 5'd31) w_state_nxt = FIX_LO;
      end
      FIX_LO: begin
        if (w_is_rem) begin
          w_add_a   = r_sa ? ~r_hi : r_hi;
          w_add_cin = r_sa;
        end else if (w_is_div) begin
          w_add_a   = w_nq ? ~r_lo : r_lo;
          w_add_cin = w_nq;
        end else begin
          w_add_a   = w_np ? ~r_lo : r_lo;
          w_add_cin = w_np;
        end
        w_state_nxt = FIX_HI;
      end
      FIX_HI: begin
        w_add_a     = w_np ? ~r_hi : r_hi;
        w_add_cin   = w_np & r_c;
        w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (kill) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_dz     <= 1'b0;
      r_c      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy <= ~kill & (r_state inside {NEG_A, NEG_B, CALC, FIX_LO, FIX_HI});
      r_done <= ~kill & (r_state == DONE);
      if (!kill) begin
        case (r_state)
          IDLE: if (start) begin
            r_op <= op;
            r_a  <= rs1;
            r_b  <= rs2;
          end
          NEG_A: begin
            r_a  <= w_sum;
            r_sa <= w_sa;
            r_dz <= w_dz;
            // Special results preloaded here; the full path reproduces them anyway.
            if (w_dz) begin
              r_lo <= '1;
              r_hi <= r_a;
            end else if (w_ovf) begin
              r_lo <= MIN_NEG;
              r_hi <= '0;
            end
          end
          NEG_B: begin
            r_b   <= w_sum;
            r_sb  <= w_sb;
            r_hi  <= '0;
            r_lo  <= w_is_div ? r_a : w_sum;
            r_cnt <= '0;
          end
          CALC: begin
            r_cnt <= w_cnt_inc;
            if (w_is_div) begin
              r_hi <= w_qbit ? w_sum : w_rs;
              r_lo <= {r_lo[XLEN-2:0], w_qbit};
            end else begin
              r_hi <= {w_cout, w_sum[XLEN-1:1]};
              r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
            end
          end
          FIX_LO: begin
            if (w_is_rem) r_hi <= w_sum;
            else          r_lo <= w_sum;
            r_c <= w_cout;
          end
          FIX_HI: if (!w_is_div) r_hi <= w_sum;
          DONE: r_result <= ((r_op == 3'd0) || (r_op[2:1] == 2'b10)) ? r_lo : r_hi;
          default: ;
        endcase
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed spec cases, control
// (kill / reset / ignored start) and randomized ops against an arithmetic model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n, start, kill;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic        busy, done;
  logic [31:0] result;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  logic [31:0] last_res;

  muldiv_seq #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .op(op),
    .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return (o[2] && b == 32'd0) ||
           ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic [31:0] r;
    bit          ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = 32'd0;
    case (o)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; start is accepted at the next posedge.
  // poke>0 re-asserts start with junk operands at that cycle of the run.
  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input int poke, input string tag);
    logic [31:0] exp;
    int          lat, n, nb;
    bit          got;
    exp = ref_model(o, a, b);
    lat = is_special(o, a, b) ? 2 : 37;
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, " done-low-after-accept"}, {31'd0, done}, 32'd0);
    n = 0; nb = 0; got = 1'b0;
    while (!got && n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (busy) nb++;
      if (done) got = 1'b1;
      else if (n == poke) begin
        start = 1'b1; op = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
      end else start = 1'b0;
    end
    start = 1'b0;
    chk({tag, " done-seen"}, {31'd0, got}, 32'd1);
    chk({tag, " latency"}, 32'(n), 32'(lat));
    chk({tag, " busy-cycles"}, 32'(nb), 32'(lat - 1));
    chk({tag, " result"}, result, exp);
    last_res = exp;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = 3'd0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    rst_n = 1'b1;

    run(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "MUL");
    chk("MUL const", result, 32'h0000_0001);
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "MULHU");
    chk("MULHU const", result, 32'hFFFF_FFFE);
    run(3'd1, 32'hFFFF_FFFE, 32'd3, 5, "MULH");
    chk("MULH const", result, 32'hFFFF_FFFF);
    run(3'd2, 32'hFFFF_FFFE, 32'h8000_0000, 20, "MULHSU");
    chk("MULHSU const", result, 32'hFFFF_FFFF);
    run(3'd4, 32'hFFFF_FFF9, 32'd2, 0, "DIV");
    chk("DIV const", result, 32'hFFFF_FFFD);
    run(3'd6, 32'hFFFF_FFF9, 32'd2, 0, "REM");
    chk("REM const", result, 32'hFFFF_FFFF);
    run(3'd5, 32'd100, 32'd7, 0, "DIVU");
    chk("DIVU const", result, 32'd14);
    run(3'd7, 32'd100, 32'd7, 0, "REMU");
    chk("REMU const", result, 32'd2);
    run(3'd5, 32'h1234, 32'd0, 0, "DIVU/0");
    chk("DIVU/0 const", result, 32'hFFFF_FFFF);
    run(3'd7, 32'h1234, 32'd0, 0, "REMU/0");
    chk("REMU/0 const", result, 32'h0000_1234);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "DIVovf");
    chk("DIVovf const", result, 32'h8000_0000);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "REMovf");
    run(3'd6, 32'hFFFF_FFF9, 32'd0, 0, "REM/0");

    // kill during CALC (10th CALC cycle), then restart the following cycle
    op = 3'd4; rs1 = 32'h0BAD_F00D; rs2 = 32'd13; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (11) begin @(posedge clk); @(negedge clk); end
    kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    kill = 1'b0;
    chk("kill busy", {31'd0, busy}, 32'd0);
    chk("kill done", {31'd0, done}, 32'd0);
    chk("kill result-held", result, last_res);
    run(3'd5, 32'hDEAD_BEEF, 32'd10, 0, "after-kill");

    // kill beats start in IDLE
    op = 3'd0; rs1 = 32'd5; rs2 = 32'd6; start = 1'b1; kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("kill-vs-start busy", {31'd0, busy}, 32'd0);
    chk("kill-vs-start result", result, last_res);

    // reset mid-DIV for two edges
    op = 3'd4; rs1 = 32'h7FFF_0000; rs2 = 32'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset done", {31'd0, done}, 32'd0);
    chk("midreset result", result, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(3'd7, 32'd1000, 32'd33, 0, "after-reset");

    repeat (60) run(3'($urandom), pick(), pick(), 0, "RND");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
